// File: rtl/dram_device_model_if.sv
// -----------------------------------------------------------------------------
// dram_device_model_if
//   Command/data bundle between a DRAM controller (master) and the
//   dram_device_model (slave). The parameters must match the ones given to the
//   model instance that connects to it.
//
//   Command side (master -> slave):
//     dram_clk_en, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
//     dram_bank_id, dram_addr (MSB = all-bank flag), dram_wr_data
//   Response/status side (slave -> master):
//     dram_rd_data, dram_rd_valid, open_banks, err_flag, err_code
// -----------------------------------------------------------------------------
interface dram_device_model_if #(
  parameter int BANK_ID_WIDTH   = 3,
  parameter int DRAM_ADDR_WIDTH = 8,
  parameter int DRAM_DATA_WIDTH = 8,
  parameter int NUMBER_OF_BANKS = 8
);
  logic                       dram_clk_en;
  logic                       dram_cs_n;
  logic                       dram_ras_n;
  logic                       dram_cas_n;
  logic                       dram_we_n;
  logic [BANK_ID_WIDTH-1:0]   dram_bank_id;
  logic [DRAM_ADDR_WIDTH-1:0] dram_addr;
  logic [DRAM_DATA_WIDTH-1:0] dram_wr_data;
  logic [DRAM_DATA_WIDTH-1:0] dram_rd_data;
  logic                       dram_rd_valid;
  logic [NUMBER_OF_BANKS-1:0] open_banks;
  logic                       err_flag;
  logic [2:0]                 err_code;

  modport master (
    output dram_clk_en, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
           dram_bank_id, dram_addr, dram_wr_data,
    input  dram_rd_data, dram_rd_valid, open_banks, err_flag, err_code
  );

  modport slave (
    input  dram_clk_en, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
           dram_bank_id, dram_addr, dram_wr_data,
    output dram_rd_data, dram_rd_valid, open_banks, err_flag, err_code
  );
endinterface

// File: rtl/dram_device_model.sv
// -----------------------------------------------------------------------------
// dram_device_model
//   Cycle-level behavioural model of a banked SDRAM device with protocol
//   checking. Decodes {ras_n,cas_n,we_n} commands, tracks open rows per bank,
//   stores write data, returns read data CAS_LATENCY edges after the READ, and
//   flags the first protocol violation in a sticky error register.
//
//   Ports:
//     u_clk    - clock, all logic on the rising edge
//     u_rst_n  - asynchronous active-low reset (memory contents are kept)
//     bus      - dram_device_model_if.slave: command inputs, read data,
//                open_banks, err_flag, err_code
//
//   Error codes: 1 READ/WRITE to closed bank, 2 ACTIVATE to open bank,
//                3 REFRESH with a bank open, 4 illegal opcode,
//                5 refresh timeout.
//
//   Optional feature: define DRAM_MODEL_REFRESH_CHECK_EN to build the refresh
//   interval down-counter that raises error code 5. Without it the counter is
//   absent and code 5 cannot occur.
// -----------------------------------------------------------------------------
module dram_device_model #(
  parameter int NUMBER_OF_COLUMNS = 8,
  parameter int NUMBER_OF_ROWS    = 128,
  parameter int NUMBER_OF_BANKS   = 8,
  parameter int DRAM_DATA_WIDTH   = 8,
  parameter int CAS_LATENCY       = 2,
  parameter int REFRESH_INTERVAL  = 1250
) (
  input logic                u_clk,
  input logic                u_rst_n,
  dram_device_model_if.slave bus
);

  localparam int COLUMN_WIDTH    = $clog2(NUMBER_OF_COLUMNS);
  localparam int ROW_WIDTH       = $clog2(NUMBER_OF_ROWS);
  localparam int BANK_ID_WIDTH   = $clog2(NUMBER_OF_BANKS);
  localparam int DRAM_ADDR_WIDTH =
    ((ROW_WIDTH > COLUMN_WIDTH) ? ROW_WIDTH : COLUMN_WIDTH) + 1;
  localparam int MEM_ADDR_WIDTH  = BANK_ID_WIDTH + ROW_WIDTH + COLUMN_WIDTH;
  localparam int MEM_DEPTH       = 1 << MEM_ADDR_WIDTH;

  if (CAS_LATENCY < 1 || CAS_LATENCY > 4) begin : g_bad_cl
    $error("dram_device_model: CAS_LATENCY must be 1..4");
  end
  if (REFRESH_INTERVAL < 1) begin : g_bad_ref
    $error("dram_device_model: REFRESH_INTERVAL must be >= 1");
  end

  typedef enum logic [2:0] {
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_CLOSED   = 3'd1,
    ERR_ACT_OPEN = 3'd2,
    ERR_REF_OPEN = 3'd3,
    ERR_ILLEGAL  = 3'd4,
    ERR_TIMEOUT  = 3'd5
  } err_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUMBER_OF_BANKS-1:0] open_q;
  logic [ROW_WIDTH-1:0]       active_row [NUMBER_OF_BANKS];
  logic [DRAM_DATA_WIDTH-1:0] mem        [MEM_DEPTH];
  logic [CAS_LATENCY:0]       rd_valid_q;
  logic [DRAM_DATA_WIDTH-1:0] rd_data_q  [CAS_LATENCY+1];
  logic                       err_flag_q;
  err_e                       err_code_q;

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic [2:0]                opcode;
  logic                      bank_open;
  logic                      all_banks;
  logic                      do_act, do_pre, do_wr, do_rd, do_ref;
  logic                      cmd_err;
  err_e                      cmd_err_code;
  logic                      timeout;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;

  // A deselected or clock-disabled cycle is a NOP.
  assign opcode    = (bus.dram_clk_en && !bus.dram_cs_n)
                   ? {bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n}
                   : CMD_NOP;
  assign bank_open = open_q[bus.dram_bank_id];
  assign all_banks = bus.dram_addr[DRAM_ADDR_WIDTH-1];
  assign mem_addr  = {bus.dram_bank_id, active_row[bus.dram_bank_id],
                      bus.dram_addr[COLUMN_WIDTH-1:0]};

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    do_act       = 1'b0;
    do_pre       = 1'b0;
    do_wr        = 1'b0;
    do_rd        = 1'b0;
    do_ref       = 1'b0;
    cmd_err      = 1'b0;
    cmd_err_code = ERR_NONE;
    case (opcode)
      CMD_NOP: ;
      CMD_ACT: begin
        if (bank_open) begin
          cmd_err      = 1'b1;
          cmd_err_code = ERR_ACT_OPEN;
        end else begin
          do_act = 1'b1;
        end
      end
      CMD_PRE: do_pre = 1'b1;
      CMD_WR, CMD_RD: begin
        if (!bank_open) begin
          cmd_err      = 1'b1;
          cmd_err_code = ERR_CLOSED;
        end else if (opcode == CMD_WR) begin
          do_wr = 1'b1;
        end else begin
          do_rd = 1'b1;
        end
      end
      CMD_REF: begin
        if (|open_q) begin
          cmd_err      = 1'b1;
          cmd_err_code = ERR_REF_OPEN;
        end else begin
          do_ref = 1'b1;
        end
      end
      default: begin
        cmd_err      = 1'b1;
        cmd_err_code = ERR_ILLEGAL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Refresh interval checker
  // ---------------------------------------------------------------------------
`ifdef DRAM_MODEL_REFRESH_CHECK_EN
  localparam int REFRESH_CNT_WIDTH = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [REFRESH_CNT_WIDTH-1:0] REFRESH_RELOAD =
    REFRESH_CNT_WIDTH'(REFRESH_INTERVAL);

  logic [REFRESH_CNT_WIDTH-1:0] refresh_cnt;

  // The counter sits at 0 for one cycle; if that edge carries no accepted
  // REFRESH it is a timeout and the counter starts a fresh interval.
  assign timeout = (refresh_cnt == '0) && !do_ref;

  always_ff @(posedge u_clk or negedge u_rst_n) begin
    if (!u_rst_n) begin
      refresh_cnt <= REFRESH_RELOAD;
    end else if (do_ref || timeout) begin
      refresh_cnt <= REFRESH_RELOAD;
    end else begin
      refresh_cnt <= refresh_cnt - 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Bank state, read pipeline, sticky error
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order or block scheduling.
  always_ff @(posedge u_clk or negedge u_rst_n) begin
    if (!u_rst_n) begin
      open_q     <= '0;
      rd_valid_q <= '0;
      for (int i = 0; i <= CAS_LATENCY; i++) rd_data_q[i] <= '0;
      err_flag_q <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      if (do_act) begin
        open_q[bus.dram_bank_id] <= 1'b1;
      end else if (do_pre) begin
        if (all_banks) open_q <= '0;
        else           open_q[bus.dram_bank_id] <= 1'b0;
      end

      // Stage 0 captures the word on the READ edge; stage CAS_LATENCY is the
      // one presented, i.e. valid in the cycle after edge T+CAS_LATENCY.
      rd_valid_q[0] <= do_rd;
      rd_data_q[0]  <= do_rd ? mem[mem_addr] : '0;
      for (int i = 1; i <= CAS_LATENCY; i++) begin
        rd_valid_q[i] <= rd_valid_q[i-1];
        rd_data_q[i]  <= rd_data_q[i-1];
      end

      // Only the first error is recorded; a command error outranks a
      // simultaneous timeout.
      if (!err_flag_q) begin
        if (cmd_err) begin
          err_flag_q <= 1'b1;
          err_code_q <= cmd_err_code;
        end else if (timeout) begin
          err_flag_q <= 1'b1;
          err_code_q <= ERR_TIMEOUT;
        end
      end
    end
  end

  // NOTE: the storage array and row latches have no reset: memory contents
  // must survive reset, and a resettable array would not map onto RAM.
  always_ff @(posedge u_clk) begin
    if (do_act) active_row[bus.dram_bank_id] <= bus.dram_addr[ROW_WIDTH-1:0];
    if (do_wr)  mem[mem_addr] <= bus.dram_wr_data;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.dram_rd_valid = rd_valid_q[CAS_LATENCY];
  assign bus.dram_rd_data  = rd_valid_q[CAS_LATENCY] ? rd_data_q[CAS_LATENCY] : '0;
  assign bus.open_banks    = open_q;
  assign bus.err_flag      = err_flag_q;
  assign bus.err_code      = err_code_q;

endmodule

// File: tb/tb_dram_device_model.sv
// -----------------------------------------------------------------------------
// tb_dram_device_model
//   Directed bench for dram_device_model. Read stimulus pushes the expected
//   word and its due cycle onto a scoreboard queue; a negedge monitor pops and
//   compares whenever dram_rd_valid is high and checks rd_data is 0 otherwise.
//   A second instance with REFRESH_INTERVAL=10 is left idle to exercise the
//   optional refresh timeout (DRAM_MODEL_REFRESH_CHECK_EN).
// -----------------------------------------------------------------------------
module tb_dram_device_model;

  localparam int CL = 2;

  localparam logic [2:0] OP_NOP = 3'b111;
  localparam logic [2:0] OP_ACT = 3'b011;
  localparam logic [2:0] OP_PRE = 3'b010;
  localparam logic [2:0] OP_WR  = 3'b100;
  localparam logic [2:0] OP_RD  = 3'b101;
  localparam logic [2:0] OP_REF = 3'b001;

  logic u_clk = 1'b0;
  logic u_rst_n;
  logic rst2_n;

  always #5 u_clk = ~u_clk;

  dram_device_model_if #(
    .BANK_ID_WIDTH(3), .DRAM_ADDR_WIDTH(8), .DRAM_DATA_WIDTH(8), .NUMBER_OF_BANKS(8)
  ) bus ();

  dram_device_model_if #(
    .BANK_ID_WIDTH(3), .DRAM_ADDR_WIDTH(8), .DRAM_DATA_WIDTH(8), .NUMBER_OF_BANKS(8)
  ) bus2 ();

  dram_device_model #(
    .NUMBER_OF_COLUMNS(8), .NUMBER_OF_ROWS(128), .NUMBER_OF_BANKS(8),
    .DRAM_DATA_WIDTH(8), .CAS_LATENCY(CL), .REFRESH_INTERVAL(1250)
  ) dut (
    .u_clk   (u_clk),
    .u_rst_n (u_rst_n),
    .bus     (bus.slave)
  );

  dram_device_model #(
    .NUMBER_OF_COLUMNS(8), .NUMBER_OF_ROWS(128), .NUMBER_OF_BANKS(8),
    .DRAM_DATA_WIDTH(8), .CAS_LATENCY(CL), .REFRESH_INTERVAL(10)
  ) dut_ref (
    .u_clk   (u_clk),
    .u_rst_n (rst2_n),
    .bus     (bus2.slave)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and checking
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   rd_seen = 0;

  always @(posedge u_clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  exp_t mon_e;
  always @(negedge u_clk) begin
    if (bus.dram_rd_valid === 1'b1) begin
      rd_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got rd_valid=1 data 0x%0h expected no read (cycle %0d)",
                 bus.dram_rd_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("rd_data", 32'(bus.dram_rd_data), 32'(mon_e.data));
        check("rd_latency", cyc, mon_e.due);
      end
    end else begin
      check("rd_data_idle_zero", 32'(bus.dram_rd_data), 32'h0);
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic drive(input logic en, input logic cs_n, input logic [2:0] op,
                       input int bank, input int addr, input logic [7:0] data);
    bus.dram_clk_en  = en;
    bus.dram_cs_n    = cs_n;
    {bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n} = op;
    bus.dram_bank_id = bank[2:0];
    bus.dram_addr    = addr[7:0];
    bus.dram_wr_data = data;
  endtask

  task automatic cmd(input logic [2:0] op, input int bank, input int addr,
                     input logic [7:0] data);
    @(negedge u_clk);
    drive(1'b1, 1'b0, op, bank, addr, data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge u_clk);
      drive(1'b1, 1'b1, OP_NOP, 0, 0, 8'h00);
    end
  endtask

  task automatic act(input int bank, input int row);
    cmd(OP_ACT, bank, row, 8'h00);
  endtask

  task automatic wr(input int bank, input int col, input logic [7:0] data);
    cmd(OP_WR, bank, col, data);
  endtask

  // Read to an open bank: the word is due in the cycle after edge T+CL.
  task automatic rd(input int bank, input int col, input logic [7:0] exp);
    cmd(OP_RD, bank, col, 8'h00);
    sb.push_back('{data: exp, due: cyc + 1 + CL});
  endtask

  task automatic pre(input int bank, input int all);
    cmd(OP_PRE, bank, (all != 0) ? 8'h80 : 8'h00, 8'h00);
  endtask

  task automatic reset_dut();
    @(negedge u_clk);
    drive(1'b1, 1'b1, OP_NOP, 0, 0, 8'h00);
    u_rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge u_clk);
    u_rst_n = 1'b1;
  endtask

  task automatic check_status(input string tag, input logic [7:0] open,
                              input logic flag, input logic [2:0] code);
    check({tag, "_open_banks"}, 32'(bus.open_banks), 32'(open));
    check({tag, "_err_flag"},   32'(bus.err_flag),   32'(flag));
    check({tag, "_err_code"},   32'(bus.err_code),   32'(code));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int rd_base;

  initial begin
    u_rst_n = 1'b0;
    rst2_n  = 1'b0;
    drive(1'b1, 1'b1, OP_NOP, 0, 0, 8'h00);
    bus2.dram_clk_en  = 1'b0;
    bus2.dram_cs_n    = 1'b1;
    bus2.dram_ras_n   = 1'b1;
    bus2.dram_cas_n   = 1'b1;
    bus2.dram_we_n    = 1'b1;
    bus2.dram_bank_id = '0;
    bus2.dram_addr    = '0;
    bus2.dram_wr_data = '0;

    // Reset state
    repeat (3) @(negedge u_clk);
    check_status("reset", 8'h00, 1'b0, 3'd0);
    check("reset_rd_valid", 32'(bus.dram_rd_valid), 32'h0);
    u_rst_n = 1'b1;
    rst2_n  = 1'b1;

    // Refresh timeout on the idle interval-10 instance: counter reaches 0
    // after 10 edges, the 11th edge without REFRESH raises code 5.
    idle(10);
`ifdef DRAM_MODEL_REFRESH_CHECK_EN
    check("timeout_not_yet", 32'(bus2.err_flag), 32'h0);
    idle(1);
    check("timeout_flag", 32'(bus2.err_flag), 32'h1);
    check("timeout_code", 32'(bus2.err_code), 32'h5);
`else
    idle(20);
    check("no_timeout_flag", 32'(bus2.err_flag), 32'h0);
    check("no_timeout_code", 32'(bus2.err_code), 32'h0);
`endif

    // Basic ACT / WRITE / READ, read-after-write on the next edge
    act(2, 5);
    wr(2, 3, 8'hA5);
    rd(2, 3, 8'hA5);
    wr(2, 4, 8'h5A);
    rd(2, 4, 8'h5A);
    idle(1);
    check_status("basic", 8'h04, 1'b0, 3'd0);

    // A different row in the same bank is separate storage
    pre(2, 0);
    act(2, 6);
    wr(2, 3, 8'h11);
    rd(2, 3, 8'h11);
    pre(2, 0);
    act(2, 5);
    rd(2, 3, 8'hA5);
    idle(CL + 2);
    check_status("rows", 8'h04, 1'b0, 3'd0);

    // Back-to-back reads, reset after the second valid pulse
    rd_base = rd_seen;
    rd(2, 3, 8'hA5);
    rd(2, 4, 8'h5A);
    rd(2, 3, 8'hA5);
    rd(2, 4, 8'h5A);
    idle(1);
    #1;
    u_rst_n = 1'b0;
    sb.delete();
    #1;
    check("burst_valids_before_reset", rd_seen - rd_base, 2);
    check("burst_rst_rd_valid", 32'(bus.dram_rd_valid), 32'h0);
    check("burst_rst_rd_data", 32'(bus.dram_rd_data), 32'h0);
    check_status("burst_rst", 8'h00, 1'b0, 3'd0);
    idle(3);
    u_rst_n = 1'b1;
    idle(CL + 2);
    check("burst_no_late_valid", rd_seen - rd_base, 2);

    // Memory survives reset
    act(2, 5);
    rd(2, 3, 8'hA5);
    idle(CL + 2);

    // READ/WRITE to a closed bank: code 1, no valid, no write; sticky code
    reset_dut();
    cmd(OP_RD, 1, 1, 8'h00);
    idle(1);
    check_status("closed_rd", 8'h00, 1'b1, 3'd1);
    act(1, 0);
    idle(1);
    check_status("closed_then_act", 8'h02, 1'b1, 3'd1);
    wr(1, 1, 8'h33);
    pre(1, 0);
    wr(1, 1, 8'h77);
    act(1, 0);
    rd(1, 1, 8'h33);
    idle(CL + 2);

    // All-bank precharge, precharge of a closed bank, legal refresh
    reset_dut();
    act(0, 1);
    act(3, 2);
    idle(1);
    check_status("two_open", 8'h09, 1'b0, 3'd0);
    pre(6, 0);
    pre(0, 1);
    cmd(OP_REF, 0, 0, 8'h00);
    idle(1);
    check_status("pre_all_ref", 8'h00, 1'b0, 3'd0);

    // REFRESH with a bank open: code 3, bank stays open
    act(4, 0);
    cmd(OP_REF, 0, 0, 8'h00);
    idle(1);
    check_status("ref_open", 8'h10, 1'b1, 3'd3);

    // ACTIVATE to an open bank: code 2, row unchanged; later errors ignored
    reset_dut();
    act(0, 1);
    wr(0, 0, 8'h42);
    act(0, 2);
    idle(1);
    check_status("act_open", 8'h01, 1'b1, 3'd2);
    rd(0, 0, 8'h42);
    cmd(3'b000, 0, 0, 8'h00);
    idle(1);
    check_status("second_err", 8'h01, 1'b1, 3'd2);
    idle(CL + 1);

    // Deselected / clock-disabled commands are NOPs; illegal opcode code 4
    reset_dut();
    @(negedge u_clk);
    drive(1'b1, 1'b1, OP_ACT, 7, 0, 8'h00);
    @(negedge u_clk);
    drive(1'b0, 1'b0, OP_ACT, 6, 0, 8'h00);
    idle(1);
    check_status("deselect", 8'h00, 1'b0, 3'd0);
    cmd(3'b110, 0, 0, 8'h00);
    idle(1);
    check_status("illegal", 8'h00, 1'b1, 3'd4);

    idle(CL + 3);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/dram_device_model.md
DRAM_DEVICE_MODEL -- requirements
Module: dram_device_model

Interface
REQ-001 SHALL have parameter NUMBER_OF_COLUMNS, default 8, columns per row.
REQ-002 SHALL have parameter NUMBER_OF_ROWS, default 128, rows per bank.
REQ-003 SHALL have parameter NUMBER_OF_BANKS, default 8, bank count.
REQ-004 SHALL have parameter DRAM_DATA_WIDTH, default 8, data word width.
REQ-005 SHALL have parameter CAS_LATENCY, default 2 (legal 1..4), READ command to data cycles.
REQ-006 SHALL have parameter REFRESH_INTERVAL, default 1250, maximum cycles allowed between REFRESH commands.
REQ-007 SHALL derive COLUMN_WIDTH=$clog2(columns), ROW_WIDTH=$clog2(rows), BANK_ID_WIDTH=$clog2(banks), DRAM_ADDR_WIDTH=max(ROW_WIDTH,COLUMN_WIDTH)+1.
REQ-008 SHALL have one clock and an asynchronous, active-low reset: u_clk in 1 clock (all logic on posedge); u_rst_n in 1 asynchronous active-low reset.
REQ-009 SHALL have the following DRAM-side ports:
- dram_clk_en in 1 command enable.
- dram_cs_n in 1 chip select.
- dram_ras_n in 1 RAS.
- dram_cas_n in 1 CAS.
- dram_we_n in 1 WE.
- dram_bank_id in BANK_ID_WIDTH bank address.
- dram_addr in DRAM_ADDR_WIDTH row/column address; MSB is the all-bank flag.
- dram_wr_data in DRAM_DATA_WIDTH write data.
- dram_rd_data out DRAM_DATA_WIDTH read data.
REQ-010 SHALL have the following status ports:
- dram_rd_valid out 1 read data valid.
- open_banks out NUMBER_OF_BANKS open-row bit per bank.
- err_flag out 1 sticky protocol error.
- err_code out 3 first error cause.

Function
REQ-011 SHALL decode {ras_n,cas_n,we_n} when clk_en=1 and cs_n=0:
- 111 NOP.
- 011 ACTIVATE.
- 010 PRECHARGE.
- 100 WRITE.
- 101 READ.
- 001 REFRESH.
- 000 or 110 ILLEGAL.
REQ-012 SHALL treat clk_en=0 or cs_n=1 as NOP; the read pipeline still advances.
REQ-013 ACTIVATE on a closed bank SHALL set open_banks[bank] and latch active_row[bank]=dram_addr[ROW_WIDTH-1:0] on the same edge.
REQ-014 PRECHARGE SHALL clear open_banks[bank], or all bits when dram_addr MSB=1; PRECHARGE of an already-closed bank SHALL be a legal no-op.
REQ-015 WRITE to an open bank SHALL store dram_wr_data at [bank][active_row][dram_addr[COLUMN_WIDTH-1:0]] on the command edge.
REQ-016 READ to an open bank issued at edge T SHALL drive the stored word on dram_rd_data with dram_rd_valid=1 for exactly one cycle following edge T+CAS_LATENCY.
REQ-017 Back-to-back READs SHALL produce valid on consecutive cycles.
REQ-018 A READ at edge T+1 to the address written at edge T SHALL return the new data.
REQ-019 When dram_rd_valid=0, dram_rd_data SHALL be 0.
REQ-020 REFRESH with all banks closed SHALL reload the refresh counter and SHALL NOT alter memory.
REQ-021 Errors SHALL set err_flag and record err_code only if err_flag was 0; both SHALL hold until reset. Codes:
- 1 READ/WRITE to a closed bank; no write, no valid.
- 2 ACTIVATE to an open bank; row unchanged.
- 3 REFRESH with any bank open; ignored.
- 4 ILLEGAL opcode.
- 5 refresh timeout.
REQ-022 If a command error and a timeout occur on the same edge, err_code SHALL record the command error.

Reset
REQ-023 While u_rst_n=0, the block SHALL hold open_banks=0, dram_rd_valid=0, dram_rd_data=0, err_flag=0, err_code=0, all read-pipeline stages empty and refresh counter=REFRESH_INTERVAL.
REQ-024 Reset asserted mid-read SHALL discard pending read data.
REQ-025 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-026 With macro DRAM_MODEL_REFRESH_CHECK_EN defined, a down-counter SHALL decrement each cycle from REFRESH_INTERVAL, reload on each accepted REFRESH, and raise error code 5 on reaching 0 with no REFRESH on that edge; it SHALL then reload.
REQ-027 Without DRAM_MODEL_REFRESH_CHECK_EN, the counter SHALL NOT be implemented and code 5 SHALL never occur.

Verification
REQ-028 ACT bank2 row5; WRITE bank2 col3 data 0xA5; READ bank2 col3 at edge T -> dram_rd_valid high one cycle after T+2, dram_rd_data=0xA5, err_flag=0.
REQ-029 READ bank1 with no prior ACT -> err_flag=1, err_code=1, no valid pulse; a following ACT bank1 row0 -> err_code stays 1.
REQ-030 ACT banks 0 and 3; PRECHARGE with addr MSB=1; REFRESH -> open_banks=0, err_flag=0.
REQ-031 ACT bank4; REFRESH -> err_code=3, open_banks[4] still 1.
REQ-032 With macro defined and REFRESH_INTERVAL=10, no REFRESH for 11 cycles -> err_code=5; without macro -> err_flag stays 0.
REQ-033 Four back-to-back READs, then u_rst_n pulsed low after the second valid -> remaining valids suppressed, all outputs 0.
